// File: rtl/cycle_run_controller.sv
// Run sequencer for the state generator / cycle checker pair: clear, seed, step and compare
// until a repeat or the step limit. Optional sticky irq output under CYCLE_RUN_IRQ_EN.
module cycle_run_controller #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned STEP_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] max_steps,
    output logic              gen_load,
    output logic              gen_step,
    output logic              chk_reset,
    output logic              chk_record,
    output logic              chk_compare,
    input  logic              chk_hit,
    output logic              busy,
    output logic              done,
    output logic              cycle_found,
    output logic              timeout,
    output logic [STEP_W-1:0] steps
`ifdef CYCLE_RUN_IRQ_EN
    ,
    input  logic              irq_clr,
    output logic              irq
`endif
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_REC0,
        S_STEP,
        S_SETTLE,
        S_CMP,
        S_SAMPLE,
        S_REC,
        S_DONE
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] limit;
    logic [SET_W-1:0]  settle_cnt;

    // Sequencer: every strobe is a registered one-cycle pulse tied to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            limit       <= '0;
            settle_cnt  <= '0;
            gen_load    <= 1'b0;
            gen_step    <= 1'b0;
            chk_reset   <= 1'b0;
            chk_record  <= 1'b0;
            chk_compare <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_found <= 1'b0;
            timeout     <= 1'b0;
            steps       <= '0;
        end else begin
            gen_load    <= 1'b0;
            gen_step    <= 1'b0;
            chk_reset   <= 1'b0;
            chk_record  <= 1'b0;
            chk_compare <= 1'b0;
            done        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        limit       <= max_steps;
                        steps       <= '0;
                        cycle_found <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        chk_reset   <= 1'b1;
                        gen_load    <= 1'b1;
                        state       <= S_CLR;
                    end
                end
                S_CLR: begin
                    chk_record <= 1'b1;
                    state      <= S_REC0;
                end
                S_REC0: begin
                    if (limit == '0) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        gen_step <= 1'b1;
                        steps    <= steps + STEP_W'(1);
                        state    <= S_STEP;
                    end
                end
                S_STEP: begin
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        chk_compare <= 1'b1;
                        state       <= S_CMP;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                S_CMP: begin
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    // A repeat takes priority over reaching the limit on the same sample.
                    if (chk_hit) begin
                        done        <= 1'b1;
                        cycle_found <= 1'b1;
                        state       <= S_DONE;
                    end else if (steps == limit) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        chk_record <= 1'b1;
                        state      <= S_REC;
                    end
                end
                S_REC: begin
                    gen_step <= 1'b1;
                    steps    <= steps + STEP_W'(1);
                    state    <= S_STEP;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // Abort cancels whatever the case above scheduled; the partial step count is kept.
            if (abort && (state != S_IDLE)) begin
                state       <= S_IDLE;
                busy        <= 1'b0;
                gen_load    <= 1'b0;
                gen_step    <= 1'b0;
                chk_reset   <= 1'b0;
                chk_record  <= 1'b0;
                chk_compare <= 1'b0;
                done        <= 1'b0;
                steps       <= steps;
                if (state != S_DONE) begin
                    cycle_found <= 1'b0;
                    timeout     <= 1'b0;
                end
            end
        end
    end

`ifdef CYCLE_RUN_IRQ_EN
    // Sticky completion interrupt; a new done takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule
